// File: rtl/xc_malu_pkg.sv
// Shared encodings for the multi-cycle ALU divide/remainder path.
package xc_malu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } divrem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } divrem_state_e;

    // Operands captured at request acceptance.
    typedef struct packed {
        divrem_op_e        op;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
    } divrem_req_t;

    function automatic logic op_is_signed(input divrem_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input divrem_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/xc_malu_divrem.sv
// One-bit-per-cycle restoring divider step logic; iteration state lives in the parent.
module xc_malu_divrem
    import xc_malu_pkg::*;
(
    input  logic              clock,
    input  logic              flush,
    input  logic              valid,
    input  logic              op_signed,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [CNT_W-1:0]  counter,
    input  logic [XLEN-1:0]   accumulator,
    input  logic [XLEN-1:0]   argument,
    output logic [XLEN-1:0]   padd_lhs,
    output logic [XLEN-1:0]   padd_rhs,
    input  logic [XLEN-1:0]   padd_result,
    input  logic              padd_borrow,
    output logic [XLEN-1:0]   n_accumulator,
    output logic [XLEN:0]     n_argument,
    output logic              finished,
    output logic [XLEN-1:0]   quotient_out,
    output logic [XLEN-1:0]   dividend_out
);

    logic              r_active;
    logic              w_rs1_neg;
    logic              w_quot_neg;
    logic              w_qbit;
    logic [CNT_W-1:0]  w_shift;
    logic [XLEN-1:0]   w_abs_rs1;
    logic [XLEN-1:0]   w_abs_rs2;
    logic [XLEN-1:0]   w_low_mask;

    assign w_rs1_neg  = op_signed && rs1[XLEN-1];
    assign w_abs_rs1  = w_rs1_neg ? (~rs1 + XLEN'(1)) : rs1;
    assign w_abs_rs2  = (op_signed && rs2[XLEN-1]) ? (~rs2 + XLEN'(1)) : rs2;
    // Division by zero keeps the all-ones quotient unsigned-looking for signed ops.
    assign w_quot_neg = op_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]) && (|rs2);

    // Step i tests the dividend window aligned with divisor << (31 - i).
    assign w_shift    = CNT_W'(XLEN-1) - counter;
    assign padd_lhs   = accumulator >> w_shift;
    assign padd_rhs   = w_abs_rs2;
    assign w_qbit     = ~padd_borrow;
    assign w_low_mask = ~({XLEN{1'b1}} << w_shift);

    always_comb begin
        n_accumulator = accumulator;
        n_argument    = {argument, w_qbit};
        if (valid) begin
            n_accumulator = w_abs_rs1;
            n_argument    = '0;
        end else if (w_qbit) begin
            n_accumulator = (padd_result << w_shift) | (accumulator & w_low_mask);
        end
    end

    assign finished     = r_active && (counter == CNT_W'(XLEN-1));
    assign quotient_out = w_quot_neg ? (~argument + XLEN'(1)) : argument;
    assign dividend_out = w_rs1_neg ? (~accumulator + XLEN'(1)) : accumulator;

    // Tracks an iteration in progress between the load cycle and the last step.
    always_ff @(posedge clock) begin
        if (flush) begin
            r_active <= 1'b0;
        end else if (valid) begin
            r_active <= 1'b1;
        end else if (finished) begin
            r_active <= 1'b0;
        end
    end

endmodule

// File: rtl/xc_malu_divrem_seq.sv
// Sequencer around xc_malu_divrem: request/response handshakes, iteration registers,
// borrow-chain subtractor and result selection.
module xc_malu_divrem_seq
    import xc_malu_pkg::*;
#(
    parameter bit FAST_DIV0 = 1'b1
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_result,
    output logic              busy
);

    divrem_state_e     r_state;
    divrem_state_e     w_state_nxt;
    divrem_req_t       r_req;
    logic [CNT_W-1:0]  r_counter;
    logic [XLEN-1:0]   r_accumulator;
    logic [XLEN-1:0]   r_argument;

    logic              w_accept;
    logic              w_rsp_fire;
    logic              w_div_flush;
    logic              w_div_valid;
    logic [XLEN-1:0]   w_padd_lhs;
    logic [XLEN-1:0]   w_padd_rhs;
    logic [XLEN-1:0]   w_padd_result;
    logic [XLEN-1:0]   w_padd_carry;
    logic [XLEN-1:0]   w_n_accumulator;
    logic [XLEN:0]     w_n_argument;
    logic              w_unused_arg_msb;
    logic              w_finished;
    logic [XLEN-1:0]   w_quotient;
    logic [XLEN-1:0]   w_dividend;
    logic [XLEN-1:0]   w_result;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_rsp_fire  = 1'b0;
        w_div_valid = 1'b0;

        if (!reset) begin
            req_ready = (r_state == ST_IDLE) && !flush;
            rsp_valid = (r_state == ST_DONE) && !flush;
            busy      = (r_state != ST_IDLE);
        end
        w_accept   = req_valid && req_ready;
        w_rsp_fire = rsp_valid && rsp_ready;

        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = (FAST_DIV0 && (req_rs2 == '0)) ? ST_DONE : ST_START;
                    end
                end
                ST_START: begin
                    w_div_valid = 1'b1;
                    w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_finished) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_rsp_fire) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_div_flush = flush || reset || w_rsp_fire;

    // Operand capture and iteration registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req         <= '0;
            r_counter     <= '0;
            r_accumulator <= '0;
            r_argument    <= '0;
        end else begin
            if (w_accept) begin
                r_req <= '{op: divrem_op_e'(req_op), rs1: req_rs1, rs2: req_rs2};
            end
            if (r_state == ST_START) begin
                r_counter     <= '0;
                r_accumulator <= w_n_accumulator;
                r_argument    <= w_n_argument[XLEN-1:0];
            end else if (r_state == ST_RUN) begin
                r_counter     <= r_counter + CNT_W'(1);
                r_accumulator <= w_n_accumulator;
                r_argument    <= w_n_argument[XLEN-1:0];
            end
        end
    end

    assign w_unused_arg_msb = w_n_argument[XLEN];

    // Ripple subtractor exposing the borrow out of every bit position.
    always_comb begin
        logic v_borrow;
        v_borrow      = 1'b0;
        w_padd_result = '0;
        w_padd_carry  = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            w_padd_result[i] = w_padd_lhs[i] ^ w_padd_rhs[i] ^ v_borrow;
            v_borrow         = (~w_padd_lhs[i] & w_padd_rhs[i])
                             | (~(w_padd_lhs[i] ^ w_padd_rhs[i]) & v_borrow);
            w_padd_carry[i]  = v_borrow;
        end
    end

    xc_malu_divrem u_divrem (
        .clock         (clock),
        .flush         (w_div_flush),
        .valid         (w_div_valid),
        .op_signed     (op_is_signed(r_req.op)),
        .rs1           (r_req.rs1),
        .rs2           (r_req.rs2),
        .counter       (r_counter),
        .accumulator   (r_accumulator),
        .argument      (r_argument),
        .padd_lhs      (w_padd_lhs),
        .padd_rhs      (w_padd_rhs),
        .padd_result   (w_padd_result),
        .padd_borrow   (w_padd_carry[XLEN-1]),
        .n_accumulator (w_n_accumulator),
        .n_argument    (w_n_argument),
        .finished      (w_finished),
        .quotient_out  (w_quotient),
        .dividend_out  (w_dividend)
    );

    always_comb begin
        w_result = '0;
        if (!reset && (r_state == ST_DONE)) begin
            if (FAST_DIV0 && (r_req.rs2 == '0)) begin
                w_result = op_is_rem(r_req.op) ? r_req.rs1 : {XLEN{1'b1}};
            end else begin
                w_result = op_is_rem(r_req.op) ? w_dividend : w_quotient;
            end
        end
    end

    assign rsp_result = w_result;

endmodule

// File: tb/tb_xc_malu_divrem_seq.sv
// Directed bench: one fast-div0 and one iterative-only instance driven in lockstep.
module tb_xc_malu_divrem_seq;

    localparam logic [1:0] DIV  = 2'd0;
    localparam logic [1:0] DIVU = 2'd1;
    localparam logic [1:0] REM  = 2'd2;
    localparam logic [1:0] REMU = 2'd3;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        rsp_ready;

    logic        f_req_ready, f_rsp_valid, f_busy;
    logic [31:0] f_rsp_result;
    logic        s_req_ready, s_rsp_valid, s_busy;
    logic [31:0] s_rsp_result;

    int errors = 0;
    int checks = 0;

    xc_malu_divrem_seq #(.FAST_DIV0(1'b1)) u_fast (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (f_req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .rsp_valid  (f_rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (f_rsp_result),
        .busy       (f_busy)
    );

    xc_malu_divrem_seq #(.FAST_DIV0(1'b0)) u_slow (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (s_req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .rsp_valid  (s_rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (s_rsp_result),
        .busy       (s_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request in the current cycle; returns just after the accepting edge.
    task automatic send(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_valid = 1'b1;
        #1;
        chk({tag, "/req_ready"}, 32'(f_req_ready & s_req_ready), 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    // Cycle k after acceptance is observed at the k-th following falling edge.
    task automatic wait_rsp(input string tag, input logic [31:0] exp,
                            input int lat_f, input int lat_s);
        int lf = 0;
        int ls = 0;
        logic [31:0] rf = '0;
        logic [31:0] rs = '0;
        for (int k = 1; k <= 40 && (lf == 0 || ls == 0); k++) begin
            @(negedge clock);
            if (lf == 0 && f_rsp_valid) begin
                lf = k;
                rf = f_rsp_result;
            end
            if (ls == 0 && s_rsp_valid) begin
                ls = k;
                rs = s_rsp_result;
            end
        end
        chk({tag, "/lat_fast"}, 32'(lf), 32'(lat_f));
        chk({tag, "/res_fast"}, rf, exp);
        chk({tag, "/lat_slow"}, 32'(ls), 32'(lat_s));
        chk({tag, "/res_slow"}, rs, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat_f, input int lat_s);
        @(negedge clock);
        send(tag, op, a, b);
        wait_rsp(tag, exp, lat_f, lat_s);
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_rs1   = '0;
        req_rs2   = '0;
        rsp_ready = 1'b1;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset/rsp_valid", 32'(f_rsp_valid | s_rsp_valid), 32'd0);
        chk("reset/busy", 32'(f_busy | s_busy), 32'd0);
        chk("reset/req_ready", 32'(f_req_ready | s_req_ready), 32'd0);
        chk("reset/rsp_result", f_rsp_result | s_rsp_result, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle/req_ready", 32'(f_req_ready & s_req_ready), 32'd1);
        chk("idle/busy", 32'(f_busy | s_busy), 32'd0);

        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 34, 34);
        run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 34, 34);
        run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 34);
        run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 34);
        run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 34);
        run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 34);
        run_op("divu_div0", DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 34);
        run_op("remu_div0", REMU, 32'h1234, 32'd0, 32'h1234, 1, 34);
        run_op("div_neg_div0", DIV, 32'h8000_0005, 32'd0, 32'hFFFF_FFFF, 1, 34);
        run_op("rem_neg_div0", REM, 32'h8000_0005, 32'd0, 32'h8000_0005, 1, 34);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 34);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34, 34);
        run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 34);
        run_op("remu_max_max", REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34, 34);
        run_op("divu_5_9", DIVU, 32'd5, 32'd9, 32'd0, 34, 34);
        run_op("remu_5_9", REMU, 32'd5, 32'd9, 32'd5, 34, 34);

        // Response backpressure, then back-to-back acceptance after the handshake.
        @(negedge clock);
        rsp_ready = 1'b0;
        send("bp", DIVU, 32'd1000, 32'd10);
        wait_rsp("bp", 32'd100, 34, 34);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp/hold_result", f_rsp_result, 32'd100);
            chk("bp/hold_valid", 32'(f_rsp_valid & s_rsp_valid), 32'd1);
            chk("bp/req_ready", 32'(f_req_ready | s_req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("bp/idle_busy", 32'(f_busy | s_busy), 32'd0);
        send("bp_next", DIVU, 32'd9, 32'd3);
        wait_rsp("bp_next", 32'd3, 34, 34);

        // Flush during an iterative run.
        @(negedge clock);
        send("flush", DIVU, 32'd50, 32'd5);
        repeat (14) @(negedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        chk("flush/busy", 32'(f_busy | s_busy), 32'd0);
        chk("flush/req_ready", 32'(f_req_ready & s_req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (f_rsp_valid || s_rsp_valid) seen++;
        end
        chk("flush/no_rsp", 32'(seen), 32'd0);
        run_op("flush_next", DIVU, 32'd9, 32'd3, 32'd3, 34, 34);

        // Flush overrides a request presented in IDLE.
        @(negedge clock);
        req_op    = DIVU;
        req_rs1   = 32'd9;
        req_rs2   = 32'd0;
        req_valid = 1'b1;
        flush     = 1'b1;
        #1;
        chk("flush_idle/req_ready", 32'(f_req_ready | s_req_ready), 32'd0);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clock);
        chk("flush_idle/busy", 32'(f_busy | s_busy), 32'd0);
        chk("flush_idle/rsp_valid", 32'(f_rsp_valid | s_rsp_valid), 32'd0);

        // Reset in the middle of an operation.
        @(negedge clock);
        send("mid_reset", DIVU, 32'd77, 32'd7);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (f_rsp_valid || s_rsp_valid || f_busy || s_busy) seen++;
        end
        chk("mid_reset/quiet", 32'(seen), 32'd0);
        run_op("post_reset", REMU, 32'd77, 32'd10, 32'd7, 34, 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
